// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with valid/ready handshakes on both sides.
// A one-entry skid buffer keeps in_ready registered while sustaining one op per cycle.
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             illegal
);

  logic [WIDTH-1:0] calc_result;
  logic             calc_zero;
  logic             calc_illegal;

  logic             s_valid;
  logic [WIDTH-1:0] s_result;
  logic             s_zero;
  logic             s_illegal;

  logic             accept;
  logic             out_fire;

  always_comb begin
    calc_result  = '0;
    calc_illegal = 1'b0;
    case (ALUControl)
      3'b000:  calc_result = SrcA + SrcB;
      3'b001:  calc_result = SrcA - SrcB;
      3'b010:  calc_result = SrcA & SrcB;
      3'b011:  calc_result = SrcA | SrcB;
      3'b101:  calc_result = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      default: calc_illegal = 1'b1;
    endcase
  end

  assign calc_zero = (calc_result == '0);
  assign in_ready  = !s_valid;
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Accepts never coincide with an S->O move because in_ready is low whenever S is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b0;
      illegal   <= 1'b0;
      s_valid   <= 1'b0;
      s_result  <= '0;
      s_zero    <= 1'b0;
      s_illegal <= 1'b0;
    end else if (accept) begin
      if (!out_valid || out_fire) begin
        out_valid <= 1'b1;
        ALUResult <= calc_result;
        Zero      <= calc_zero;
        illegal   <= calc_illegal;
      end else begin
        s_valid   <= 1'b1;
        s_result  <= calc_result;
        s_zero    <= calc_zero;
        s_illegal <= calc_illegal;
      end
    end else if (out_fire) begin
      if (s_valid) begin
        ALUResult <= s_result;
        Zero      <= s_zero;
        illegal   <= s_illegal;
        s_valid   <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: an in-order queue model checked every cycle,
// plus hand-computed literal results attached to each directed vector.
module tb_alu_exec_stage;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic        zero;
  logic        illegal;

  int tests_run    = 0;
  int tests_failed = 0;

  exp_t        q[$];
  exp_t        lit_q[$];
  exp_t        lit_cur;
  exp_t        pend_item;
  exp_t        pend_lit;
  logic        pend_push = 1'b0;
  logic        pend_pop  = 1'b0;
  logic        have_prev = 1'b0;
  logic [31:0] prev_res  = '0;

  alu_exec_stage #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (alu_control),
    .SrcA       (src_a),
    .SrcB       (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (alu_result),
    .Zero       (zero),
    .illegal    (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic exp_t model_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.ill = 1'b0;
    case (c)
      3'd0:    e.res = a + b;
      3'd1:    e.res = a - b;
      3'd2:    e.res = a & b;
      3'd3:    e.res = a | b;
      3'd5:    e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin e.res = 32'd0; e.ill = 1'b1; end
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the edge that accepted the op.
  task automatic applyStimulus(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] er, input logic ez, input logic ei);
    in_valid    = 1'b1;
    alu_control = c;
    src_a       = a;
    src_b       = b;
    lit_cur     = '{res: er, zero: ez, ill: ei};
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL accept_timeout: op %0d never accepted, in_ready=%0b", c, in_ready);
    in_valid = 1'b0;
  endtask

  always @(negedge rst_n) begin
    q.delete();
    lit_q.delete();
    pend_push = 1'b0;
    pend_pop  = 1'b0;
    have_prev = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("in_ready", in_ready, q.size() < 2);
      checkOutput("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
        checkOutput("model_result", alu_result, q[0].res);
        checkOutput("model_zero", zero, q[0].zero);
        checkOutput("model_illegal", illegal, q[0].ill);
        if (out_ready && lit_q.size() > 0) begin
          checkOutput("literal_result", alu_result, lit_q[0].res);
          checkOutput("literal_zero", zero, lit_q[0].zero);
          checkOutput("literal_illegal", illegal, lit_q[0].ill);
        end
      end
      if (have_prev) checkOutput("stall_hold", alu_result, prev_res);
      have_prev = (q.size() > 0) && !out_ready;
      prev_res  = alu_result;
      pend_pop  = (q.size() > 0) && out_ready;
      pend_push = in_valid && (q.size() < 2);
      pend_item = model_op(alu_control, src_a, src_b);
      pend_lit  = lit_cur;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (pend_pop) begin
        void'(q.pop_front());
        void'(lit_q.pop_front());
      end
      if (pend_push) begin
        q.push_back(pend_item);
        lit_q.push_back(pend_lit);
      end
      pend_pop  = 1'b0;
      pend_push = 1'b0;
    end
  end

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    alu_control = 3'd0;
    src_a       = '0;
    src_b       = '0;
    lit_cur     = '0;
    #3;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_result", alu_result, 0);
    checkOutput("reset_zero", zero, 0);
    checkOutput("reset_illegal", illegal, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Add/sub back-to-back, wrap
    applyStimulus(3'b000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b0);
    applyStimulus(3'b001, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
    applyStimulus(3'b001, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b0);

    // Logic and slt
    applyStimulus(3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0);
    applyStimulus(3'b011, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0);
    applyStimulus(3'b101, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    applyStimulus(3'b101, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0);

    // Illegal codes followed by a legal add
    applyStimulus(3'b100, 32'h12345678, 32'h9ABCDEF0, 32'd0, 1'b1, 1'b1);
    applyStimulus(3'b111, 32'hDEADBEEF, 32'd7, 32'd0, 1'b1, 1'b1);
    applyStimulus(3'b110, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1);
    applyStimulus(3'b000, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Backpressure: A and B absorbed, C waits until out_ready rises
    out_ready = 1'b0;
    fork
      begin
        applyStimulus(3'b000, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0);
        applyStimulus(3'b001, 32'd100, 32'd1, 32'd99, 1'b0, 1'b0);
        applyStimulus(3'b011, 32'h0F, 32'hF0, 32'hFF, 1'b0, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        checkOutput("bp_in_ready_low", in_ready, 0);
        checkOutput("bp_head_is_a", alu_result, 32'd30);
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Reset mid-operation with O and S full
    out_ready = 1'b0;
    applyStimulus(3'b000, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
    applyStimulus(3'b000, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_result", alu_result, 0);
    checkOutput("midrst_zero", zero, 0);
    checkOutput("midrst_illegal", illegal, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(3'b000, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);
    checkOutput("post_rst_valid", out_valid, 1);
    checkOutput("post_rst_result", alu_result, 32'd5);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("drained", out_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage directly downstream of the ALU decoder: consumes the 3-bit `ALUControl` code plus two operands and produces the ALU result, `Zero` flag and an illegal-op flag one cycle later. Input and output use valid/ready handshakes. A one-entry skid buffer lets `in_ready` be a registered signal while still sustaining one operation per cycle. It sits between decode/operand select and the writeback/branch logic when the core is run with a registered execute boundary.

## Interface
- `WIDTH`, default 32: operand and result width in bits (≥ 2).
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `in_valid`  input  1  operation presented on `ALUControl`/`SrcA`/`SrcB`.
- `in_ready`  output  1  stage can accept; equals NOT skid-buffer-occupied (registered state).
- `ALUControl`  input  3  000 add, 001 sub, 010 and, 011 or, 101 slt (signed); all other codes are illegal.
- `SrcA`  input  WIDTH  operand A.
- `SrcB`  input  WIDTH  operand B.
- `out_valid`  output  1  output register holds a result.
- `out_ready`  input  1  consumer accepts the result this cycle.
- `ALUResult`  output  WIDTH  registered result.
- `Zero`  output  1  registered; 1 iff `ALUResult == 0`.
- `illegal`  output  1  registered; 1 if the op carried an illegal `ALUControl` code.

## Operation
- Accept (input fire) = `in_valid && in_ready`. Output fire = `out_valid && out_ready`.
- Result is computed combinationally from the inputs at accept and captured with its flags; the registered copy never recomputes.
- Arithmetic is modulo 2^WIDTH. Add/sub wrap silently; there is no carry or overflow output.
- slt: result = {WIDTH-1 zeros, (signed SrcA < signed SrcB)}.
- Illegal code: result = 0, `Zero` = 1, `illegal` = 1. The op is still accepted and delivered in order.
- Storage: output register (O) plus skid register (S), each with a valid bit.
- On accept:
  - If O is empty or O is firing this cycle, the new result loads O.
  - Otherwise the new result loads S.
- On output fire with S valid and no accept: S moves to O and S empties.
- S can only be occupied while O is occupied and stalled. Because `in_ready` = !S.valid, an accept and an S→O move never occur in the same cycle.
- Results leave in strict acceptance order. There is no drop and no duplication.
- Outputs hold stable while `out_valid && !out_ready`.
- When `in_valid` is low, the values on `ALUControl`/`SrcA`/`SrcB` are ignored.

## Timing
- Reset values (asynchronous, applied immediately on `rst_n` = 0):
  - `out_valid` = 0, `ALUResult` = 0, `Zero` = 0, `illegal` = 0.
  - S empty, so `in_ready` = 1.
  - Data registers in S cleared to 0.
- Reset release is synchronous to `clk`; the first accept can occur on the first rising edge after `rst_n` goes high.
- Latency: an op accepted at edge N appears with `out_valid` = 1 after edge N (visible in cycle N+1).
- Throughput: one op per cycle while `out_ready` stays high. With `out_ready` low, the stage absorbs exactly two ops (O + S), then drops `in_ready`.
- `in_ready` rises in the cycle after the edge where S drains into O.
- Reset asserted mid-operation discards O and S contents. No result is emitted for ops accepted before reset.
- `Zero` and `illegal` change only on the same edges as `ALUResult`.

## Test plan
- Add/sub, `out_ready`=1:
  - ALUControl=000, SrcA=0x7FFFFFFF, SrcB=1 -> next cycle ALUResult=0x80000000, Zero=0.
  - Then 001 with 5,5 -> ALUResult=0, Zero=1.
  - Back-to-back, one result per cycle.
- Logic and slt:
  - 010 with 0xF0F0F0F0 & 0x0FF00FF0 -> 0x00F000F0.
  - 011 -> 0xFFF0FFF0.
  - 101 with SrcA=0xFFFFFFFF (-1), SrcB=1 -> 1.
  - 101 with SrcA=1, SrcB=0xFFFFFFFF -> 0.
- Backpressure: hold `out_ready`=0, present ops A, B, C on consecutive cycles.
  - A and B are accepted; `in_ready` drops after B, so C waits.
  - Raise `out_ready` -> A, B, C delivered in order.
  - `ALUResult` stays stable while stalled.
- Illegal code: ALUControl=100, then 111, with nonzero operands -> each result is 0 with Zero=1 and illegal=1. A following legal add gives illegal=0.
- Wrap: 001 with SrcA=0, SrcB=1 -> 0xFFFFFFFF, Zero=0.
- Reset mid-operation: fill O and S under backpressure, pulse `rst_n` low asynchronously between edges.
  - Outputs go to 0 immediately; `in_ready`=1.
  - After release, no stale result appears and a new add of 2+3 returns 5 one cycle after accept.
